// File: rtl/dm_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
//   state_t     : controller FSM states (IDLE, BUSY_P pipeline access, BUSY_H host access)
//   *_DEF       : default data/address widths, burst limit and ack timeout
//   cntWidth()  : bits needed to hold a counter value 0..maxVal
package dm_ctrl_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 8;
  localparam int PIPE_BURST_DEF  = 4;
  localparam int ACK_TIMEOUT_DEF = 15;

  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

  // Width of the ack timeout counter for the default timeout.
  localparam int TMO_W_DEF = cntWidth(ACK_TIMEOUT_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_P = 2'd1,
    BUSY_H = 2'd2
  } state_t;

endpackage

// File: rtl/dm_ack_timer.sv
// Ack watchdog for one memory access.
//   clk, rst : clock, synchronous active-high reset
//   clr      : hold the count at zero (controller idle)
//   run      : request outstanding and not acked this cycle
//   expire   : combinational; this is the ACK_TIMEOUT-th unacked request cycle
module dm_ack_timer
  import dm_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = cntWidth(ACK_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // cnt = number of unacked request cycles already elapsed; the cycle in which
  // it equals ACK_TIMEOUT-1 is the last one allowed.
  always_ff @(posedge clk) begin
    if (rst || clr)                cnt <= '0;
    else if (run && cnt != LAST)   cnt <= cnt + CW'(1);
  end

  assign expire = run && (cnt == LAST);

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: arbitrates a single-port, variable-latency DM
// between the MEM stage and a host/loader port and runs the req/ack handshake.
//   clk, rst                          : clock, synchronous active-high reset
//   pipe_rd_i/wr_i/addr_i/wdata_i     : MEM-stage request (level, held while stalled)
//   pipe_rdata_o, pipe_stall_o        : registered read data, combinational stall
//   host_req_i/we_i/addr_i/wdata_i    : host request, held until host_done_o
//   host_done_o, host_rdata_o         : one-cycle completion pulse and read data
//   mem_req_o/we_o/addr_o/wdata_o     : registered DM request, stable until ack/abort
//   mem_ack_i, mem_rdata_i            : DM completion and read data
//   err_o                             : sticky timeout / read+write conflict flag
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int PIPE_BURST  = PIPE_BURST_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_rd_i,
  input  logic                  pipe_wr_i,
  input  logic [ADDR_WIDTH-1:0] pipe_addr_i,
  input  logic [DATA_WIDTH-1:0] pipe_wdata_i,
  output logic [DATA_WIDTH-1:0] pipe_rdata_o,
  output logic                  pipe_stall_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_done_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  localparam int BW = cntWidth(PIPE_BURST);
  localparam logic [BW-1:0] BURST_MAX = BW'(PIPE_BURST);

  state_t        state, stateNxt;
  logic          pipeReq, hostReq, busy, ackIn, tmoHit, finish, grantP, grantH;
  logic [BW-1:0] burst;

  assign pipeReq = pipe_rd_i | pipe_wr_i;
  // The host still holds its request during the done cycle; masking it there
  // keeps a completed host access from being granted a second time.
  assign hostReq = host_req_i & ~host_done_o;
  assign busy    = (state != IDLE);
  assign ackIn   = mem_req_o & mem_ack_i;
  assign finish  = busy & (ackIn | tmoHit);

  assign pipe_stall_o = pipeReq & ~((state == BUSY_P) & (ackIn | tmoHit));

  // Timer only counts unacked cycles, so an ack in the last allowed cycle wins.
  dm_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clr    (~busy),
    .run    (busy & ~ackIn),
    .expire (tmoHit)
  );

  always_comb begin
    stateNxt = state;
    grantP   = 1'b0;
    grantH   = 1'b0;
    case (state)
      IDLE: begin
        if (pipeReq && !(hostReq && burst == BURST_MAX)) begin
          stateNxt = BUSY_P;
          grantP   = 1'b1;
        end else if (hostReq) begin
          stateNxt = BUSY_H;
          grantH   = 1'b1;
        end
      end
      BUSY_P, BUSY_H: if (finish) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      burst        <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      pipe_rdata_o <= '0;
      host_rdata_o <= '0;
      host_done_o  <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state       <= stateNxt;
      host_done_o <= 1'b0;

      // Request fields are latched only on grant and held for the whole access.
      if (grantP) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= pipe_wr_i;           // rd+wr together executes as a write
        mem_addr_o  <= pipe_addr_i;
        mem_wdata_o <= pipe_wdata_i;
      end else if (grantH) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= host_we_i;
        mem_addr_o  <= host_addr_i;
        mem_wdata_o <= host_wdata_i;
      end else if (finish) begin
        mem_req_o   <= 1'b0;
      end

      // Aborted reads return zero.
      if (state == BUSY_P && finish && !mem_we_o)
        pipe_rdata_o <= ackIn ? mem_rdata_i : '0;
      if (state == BUSY_H && finish) begin
        host_rdata_o <= ackIn ? mem_rdata_i : '0;
        host_done_o  <= 1'b1;
      end

      if ((pipe_rd_i && pipe_wr_i) || tmoHit) err_o <= 1'b1;

      // Starvation guard: count pipe grants that jump a waiting host.
      if (!hostReq || grantH)                 burst <= '0;
      else if (grantP && burst != BURST_MAX)  burst <= burst + BW'(1);
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: randomized pipe/host accesses against
// a memory responder with per-access latency, checked with a transaction-level
// model (reference memory, latency arithmetic, sticky error flag).
module tb_dm_access_ctrl;
  localparam int DW = 16, AW = 8, PB = 4, TMO = 15;
  localparam logic [AW-1:0] FAIR_PA = 8'h30, FAIR_HA = 8'h40;

  logic clk = 1'b0, rst = 1'b1;
  logic          pipe_rd_i = 1'b0, pipe_wr_i = 1'b0;
  logic [AW-1:0] pipe_addr_i = '0;
  logic [DW-1:0] pipe_wdata_i = '0;
  logic [DW-1:0] pipe_rdata_o;
  logic          pipe_stall_o;
  logic          host_req_i = 1'b0, host_we_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [DW-1:0] host_wdata_i = '0;
  logic          host_done_o;
  logic [DW-1:0] host_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          err_o;

  logic ackResp = 1'b0, forceAck = 1'b0;
  assign mem_ack_i = ackResp | forceAck;

  dm_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_BURST(PB), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .pipe_rd_i(pipe_rd_i), .pipe_wr_i(pipe_wr_i), .pipe_addr_i(pipe_addr_i),
    .pipe_wdata_i(pipe_wdata_i), .pipe_rdata_o(pipe_rdata_o), .pipe_stall_o(pipe_stall_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_done_o(host_done_o), .host_rdata_o(host_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initVal(input int i);
    if (i == 'h10) return 16'hBEEF;
    return DW'((i * 40503) ^ 23130) | DW'(1);
  endfunction

  // ---------------- memory responder ----------------
  logic [DW-1:0] memArr [256];
  logic [DW-1:0] refMem [256];
  bit            memInit = 1'b0;
  int            memLat = 1;          // 0 = never ack
  bit            inReq = 1'b0;
  int            reqCyc = 0;
  logic [AW-1:0] capAddr = '0;
  logic          capWe = 1'b0;
  logic [DW-1:0] capWdata = '0;
  bit            stableOk = 1'b1;
  logic [AW-1:0] grantQ [$];

  always @(negedge clk) begin
    if (mem_req_o) begin
      if (!inReq) begin
        inReq       <= 1'b1;
        reqCyc      <= 1;
        capAddr     <= mem_addr_o;
        capWe       <= mem_we_o;
        capWdata    <= mem_wdata_o;
        stableOk    <= 1'b1;
        ackResp     <= (memLat == 1);
        mem_rdata_i <= memArr[mem_addr_o];
        grantQ.push_back(mem_addr_o);
      end else begin
        reqCyc <= reqCyc + 1;
        if (mem_addr_o != capAddr || mem_we_o != capWe || mem_wdata_o != capWdata)
          stableOk <= 1'b0;
        ackResp <= (memLat != 0) && (reqCyc + 1 == memLat);
      end
    end else begin
      inReq   <= 1'b0;
      ackResp <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) memArr[i] <= initVal(i);
      memInit <= 1'b1;
    end else if (mem_req_o && mem_ack_i && mem_we_o) begin
      memArr[mem_addr_o] <= mem_wdata_o;
    end
  end

  // ---------------- checking ----------------
  int nChk = 0, nPass = 0;
  logic [DW-1:0] lastPipeRd = '0;
  bit errExp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pipeOp(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int lat);
    int n, expCyc;
    bit fin;
    expCyc = (lat == 0) ? TMO : lat;
    @(negedge clk);
    memLat = lat; pipe_rd_i = rd; pipe_wr_i = wr; pipe_addr_i = a; pipe_wdata_i = d;
    n = 0; fin = 1'b0;
    for (int c = 0; c < TMO + 8 && !fin; c++) begin
      #2;
      if (pipe_stall_o) begin n++; @(negedge clk); end
      else fin = 1'b1;
    end
    chk("p_release", fin, 1);
    chk("p_stallcyc", n, expCyc);
    chk("p_addr", capAddr, a);
    chk("p_we", capWe, wr);
    if (wr) chk("p_wdata", capWdata, d);
    chk("p_stable", stableOk, 1);
    chk("p_reqcyc", reqCyc, expCyc);
    if (wr && lat != 0) refMem[a] = d;
    if (rd && !wr) lastPipeRd = (lat == 0) ? 16'h0 : refMem[a];
    errExp = errExp | (rd & wr) | (lat == 0);
    @(negedge clk);
    pipe_rd_i = 1'b0; pipe_wr_i = 1'b0;
    #2;
    chk("p_rdata", pipe_rdata_o, lastPipeRd);
    chk("p_err", err_o, errExp);
  endtask

  task automatic hostOp(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int lat);
    int n, expCyc;
    bit got;
    logic [DW-1:0] rdv;
    expCyc = (lat == 0) ? TMO : lat;
    @(negedge clk);
    memLat = lat; host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_wdata_i = d;
    n = 0; got = 1'b0; rdv = '0;
    for (int c = 0; c < TMO + 8 && !got; c++) begin
      #2;
      if (host_done_o) begin got = 1'b1; rdv = host_rdata_o; end
      else begin n++; @(negedge clk); end
    end
    host_req_i = 1'b0;
    chk("h_done", got, 1);
    chk("h_donecyc", n, expCyc + 1);
    chk("h_addr", capAddr, a);
    chk("h_we", capWe, we);
    if (we) chk("h_wdata", capWdata, d);
    chk("h_stable", stableOk, 1);
    chk("h_reqcyc", reqCyc, expCyc);
    if (!we) chk("h_rdata", rdv, (lat == 0) ? 16'h0 : refMem[a]);
    if (we && lat != 0) refMem[a] = d;
    errExp = errExp | (lat == 0);
    @(negedge clk);
    #2;
    chk("h_onepulse", host_done_o, 0);
    chk("h_err", err_o, errExp);
  endtask

  initial begin
    int lat, dn, nP, nH, hostIdx;
    logic [AW-1:0] a;
    logic [DW-1:0] d, hrd;
    bit isHost, isWr;

    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_outs", {pipe_rdata_o, pipe_stall_o, host_done_o, host_rdata_o, mem_req_o,
                     mem_we_o, mem_addr_o, mem_wdata_o, err_o}, 64'd0);
    rst = 1'b0;

    // directed: minimal read, slow write, read-back, ack on the timeout cycle
    pipeOp(1'b1, 1'b0, 8'h10, 16'h0, 1);
    chk("beef", pipe_rdata_o, 16'hBEEF);
    pipeOp(1'b0, 1'b1, 8'h20, 16'h1234, 3);
    pipeOp(1'b1, 1'b0, 8'h20, 16'h0, 2);
    pipeOp(1'b1, 1'b0, 8'h11, 16'h0, TMO);
    hostOp(1'b0, 8'h20, 16'h0, 1);

    // randomized mix, no errors expected
    for (int k = 0; k < 40; k++) begin
      lat    = $urandom_range(1, 6);
      a      = AW'($urandom_range(0, 31));
      d      = DW'($urandom);
      isHost = 1'($urandom_range(0, 1));
      isWr   = 1'($urandom_range(0, 1));
      if (isHost) hostOp(isWr, a, d, lat);
      else        pipeOp(!isWr, isWr, a, d, lat);
    end

    // fairness: host waiting while the pipe requests every cycle
    @(negedge clk);
    grantQ.delete();
    memLat = 1; pipe_rd_i = 1'b1; pipe_wr_i = 1'b0; pipe_addr_i = FAIR_PA;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = FAIR_HA;
    dn = 0; hrd = '0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (host_done_o) begin dn++; hrd = host_rdata_o; host_req_i = 1'b0; end
      @(negedge clk);
    end
    pipe_rd_i = 1'b0;
    host_req_i = 1'b0;
    repeat (3) @(negedge clk);
    nP = 0; nH = 0; hostIdx = -1;
    foreach (grantQ[i]) begin
      if (grantQ[i] == FAIR_HA) begin nH++; if (hostIdx < 0) hostIdx = i; end
      else if (hostIdx < 0) nP++;
    end
    chk("fair_burst", nP, PB);
    chk("fair_hgrants", nH, 1);
    chk("fair_donepulses", dn, 1);
    chk("fair_hrdata", hrd, refMem[FAIR_HA]);
    lastPipeRd = refMem[FAIR_PA];
    #2;
    chk("fair_prdata", pipe_rdata_o, lastPipeRd);

    // error cases: rd+wr conflict, pipe and host timeouts, sticky flag
    pipeOp(1'b1, 1'b1, 8'h05, 16'hCAFE, 2);
    pipeOp(1'b1, 1'b0, 8'h05, 16'h0, 1);
    pipeOp(1'b1, 1'b0, 8'h12, 16'h0, 0);
    hostOp(1'b0, 8'h13, 16'h0, 0);
    pipeOp(1'b0, 1'b1, 8'h14, 16'h7777, 0);
    pipeOp(1'b1, 1'b0, 8'h14, 16'h0, 1);

    // reset during a host access, with a stray ack afterwards
    @(negedge clk);
    memLat = 0; host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 8'h15;
    @(negedge clk);
    #2;
    chk("rt_busy", mem_req_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; host_req_i = 1'b0; forceAck = 1'b1;
    #2;
    chk("rt_outs", {pipe_rdata_o, pipe_stall_o, host_done_o, host_rdata_o, mem_req_o,
                    mem_we_o, mem_addr_o, mem_wdata_o, err_o}, 64'd0);
    @(negedge clk);
    forceAck = 1'b0;
    #2;
    chk("rt_nodone", host_done_o, 0);
    chk("rt_noreq", mem_req_o, 0);
    errExp = 1'b0; lastPipeRd = '0;
    pipeOp(1'b1, 1'b0, 8'h16, 16'h0, 2);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
